// File: rtl/tinyml_cam_2ppc_to_1ppc_fifo.sv
//------------------------------------------------------------------------------
// Module      : tinyml_cam_2ppc_to_1ppc_fifo
// Description : Buffers 2-pixel-per-clock RGB pairs in a small FIFO and
//               serialises them into a 1-pixel-per-clock valid/ready stream
//               with x/y coordinates and start-of-frame / end-of-line markers.
//               Optional: TINYML_CAM_FRAME_RESYNC_EN adds in_sof, which
//               re-anchors the coordinate counters at the flagged pair.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tinyml_cam_2ppc_to_1ppc_fifo #(
   parameter int P_DEPTH          = 8,
   parameter int OUT_FRAME_WIDTH  = 540,
   parameter int OUT_FRAME_HEIGHT = 300,
   parameter int FIFO_AW          = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [2*P_DEPTH-1:0]   in_red,
   input  logic [2*P_DEPTH-1:0]   in_green,
   input  logic [2*P_DEPTH-1:0]   in_blue,
   input  logic                   in_valid,
`ifdef TINYML_CAM_FRAME_RESYNC_EN
   input  logic                   in_sof,
`endif
   output logic                   fifo_full,
   output logic                   overflow,
   input  logic                   overflow_clr,
   output logic [P_DEPTH-1:0]     out_red,
   output logic [P_DEPTH-1:0]     out_green,
   output logic [P_DEPTH-1:0]     out_blue,
   output logic [10:0]            out_x,
   output logic [10:0]            out_y,
   output logic                   out_sof,
   output logic                   out_eol,
   output logic                   out_valid,
   input  logic                   out_ready
);

   localparam int DEPTH = 1 << FIFO_AW;
`ifdef TINYML_CAM_FRAME_RESYNC_EN
   localparam int FW = 6*P_DEPTH + 1;
`else
   localparam int FW = 6*P_DEPTH;
`endif
   localparam logic [FIFO_AW:0] C_COUNT_FULL = (FIFO_AW+1)'(DEPTH);
   localparam logic [10:0]      C_X_LAST     = 11'(OUT_FRAME_WIDTH - 1);
   localparam logic [10:0]      C_Y_LAST     = 11'(OUT_FRAME_HEIGHT - 1);

   logic [FW-1:0]        mem_q [DEPTH];
   logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]     count_q, count_d;
   logic                 half_q, half_d;
   logic [10:0]          x_q, x_d;
   logic [10:0]          y_q, y_d;
   logic                 overflow_q, overflow_d;
   logic [P_DEPTH-1:0]   out_red_q, out_red_d;
   logic [P_DEPTH-1:0]   out_green_q, out_green_d;
   logic [P_DEPTH-1:0]   out_blue_q, out_blue_d;
   logic [10:0]          out_x_q, out_x_d;
   logic [10:0]          out_y_q, out_y_d;
   logic                 out_sof_q, out_sof_d;
   logic                 out_eol_q, out_eol_d;
   logic                 out_valid_q, out_valid_d;

   logic                 fifo_empty;
   logic                 wr_en;
   logic                 drop;
   logic                 load;
   logic                 take;
   logic                 pop;
   logic                 resync;
   logic                 head_sof;
   logic [FW-1:0]        wr_data;
   logic [FW-1:0]        head;
   logic [10:0]          cur_x;
   logic [10:0]          cur_y;

   assign fifo_full  = (count_q == C_COUNT_FULL);
   assign fifo_empty = (count_q == '0);
   assign wr_en      = in_valid & ~fifo_full;
   assign drop       = in_valid & fifo_full;
   assign load       = ~out_valid_q | out_ready;
   assign take       = load & ~fifo_empty;
   assign pop        = take & half_q;
   assign head       = mem_q[rd_ptr_q];

`ifdef TINYML_CAM_FRAME_RESYNC_EN
   assign wr_data  = {in_sof, in_blue, in_green, in_red};
   assign head_sof = head[6*P_DEPTH];
`else
   assign wr_data  = {in_blue, in_green, in_red};
   assign head_sof = 1'b0;
`endif

   // Resync only applies when the even half of a flagged pair is loaded.
   assign resync = take & ~half_q & head_sof;
   assign cur_x  = resync ? 11'd0 : x_q;
   assign cur_y  = resync ? 11'd0 : y_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      half_d      = half_q;
      x_d         = x_q;
      y_d         = y_q;
      overflow_d  = overflow_q;
      out_red_d   = out_red_q;
      out_green_d = out_green_q;
      out_blue_d  = out_blue_q;
      out_x_d     = out_x_q;
      out_y_d     = out_y_q;
      out_sof_d   = out_sof_q;
      out_eol_d   = out_eol_q;
      out_valid_d = out_valid_q;

      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({wr_en, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (drop) begin
         overflow_d = 1'b1;
      end else if (overflow_clr) begin
         overflow_d = 1'b0;
      end

      // A loaded pixel is always accepted before the next load, so the
      // coordinate counters advance at load time and are stored with it.
      if (load) begin
         if (fifo_empty) begin
            out_valid_d = 1'b0;
         end else begin
            out_valid_d = 1'b1;
            if (half_q) begin
               out_red_d   = head[2*P_DEPTH-1:P_DEPTH];
               out_green_d = head[4*P_DEPTH-1:3*P_DEPTH];
               out_blue_d  = head[6*P_DEPTH-1:5*P_DEPTH];
            end else begin
               out_red_d   = head[P_DEPTH-1:0];
               out_green_d = head[3*P_DEPTH-1:2*P_DEPTH];
               out_blue_d  = head[5*P_DEPTH-1:4*P_DEPTH];
            end
            half_d    = ~half_q;
            out_x_d   = cur_x;
            out_y_d   = cur_y;
            out_sof_d = (cur_x == 11'd0) && (cur_y == 11'd0);
            out_eol_d = (cur_x == C_X_LAST);
            if (cur_x == C_X_LAST) begin
               x_d = 11'd0;
               y_d = (cur_y == C_Y_LAST) ? 11'd0 : cur_y + 11'd1;
            end else begin
               x_d = cur_x + 11'd1;
               y_d = cur_y;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         half_q      <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         overflow_q  <= 1'b0;
         out_red_q   <= '0;
         out_green_q <= '0;
         out_blue_q  <= '0;
         out_x_q     <= '0;
         out_y_q     <= '0;
         out_sof_q   <= 1'b0;
         out_eol_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         half_q      <= half_d;
         x_q         <= x_d;
         y_q         <= y_d;
         overflow_q  <= overflow_d;
         out_red_q   <= out_red_d;
         out_green_q <= out_green_d;
         out_blue_q  <= out_blue_d;
         out_x_q     <= out_x_d;
         out_y_q     <= out_y_d;
         out_sof_q   <= out_sof_d;
         out_eol_q   <= out_eol_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign overflow  = overflow_q;
   assign out_red   = out_red_q;
   assign out_green = out_green_q;
   assign out_blue  = out_blue_q;
   assign out_x     = out_x_q;
   assign out_y     = out_y_q;
   assign out_sof   = out_sof_q;
   assign out_eol   = out_eol_q;
   assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_tinyml_cam_2ppc_to_1ppc_fifo.sv
//------------------------------------------------------------------------------
// Module      : tb_tinyml_cam_2ppc_to_1ppc_fifo
// Description : Directed bench for the 2ppc-to-1ppc FIFO: latency, line,
//               overflow, stall, frame wrap and asynchronous reset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_tinyml_cam_2ppc_to_1ppc_fifo;

   localparam int PD = 8;
   localparam int W  = 540;
   localparam int H  = 3;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [15:0]   in_red = '0, in_green = '0, in_blue = '0;
   logic          in_valid = 1'b0;
`ifdef TINYML_CAM_FRAME_RESYNC_EN
   logic          in_sof = 1'b0;
`endif
   logic          fifo_full, overflow;
   logic          overflow_clr = 1'b0;
   logic [7:0]    out_red, out_green, out_blue;
   logic [10:0]   out_x, out_y;
   logic          out_sof, out_eol, out_valid;
   logic          out_ready = 1'b0;

   always #5 clk = ~clk;

   tinyml_cam_2ppc_to_1ppc_fifo #(
      .P_DEPTH(PD), .OUT_FRAME_WIDTH(W), .OUT_FRAME_HEIGHT(H), .FIFO_AW(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
      .in_valid(in_valid),
`ifdef TINYML_CAM_FRAME_RESYNC_EN
      .in_sof(in_sof),
`endif
      .fifo_full(fifo_full), .overflow(overflow), .overflow_clr(overflow_clr),
      .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
      .out_x(out_x), .out_y(out_y), .out_sof(out_sof), .out_eol(out_eol),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   int          n_total = 0;
   int          n_bad   = 0;
   logic [24:0] exp_q[$];
   int          ex = 0, ey = 0;
   bit          prev_last = 0, wrap_seen = 0;
   int          eol_cnt = 0;
   logic [24:0] e;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {blue_pair, green_pair, red_pair}; low byte of each is the even pixel
   function automatic logic [47:0] pair_val(input int idx);
      logic [7:0] a, c;
      a = idx[7:0];
      c = idx[15:8];
      return {c ^ 8'hC3, c + 8'h11, a + 8'h77, a ^ 8'h5A, ~a, a};
   endfunction

   task automatic send_raw(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b,
                           input bit keep, input bit sof, input bit clr);
      in_red = r; in_green = g; in_blue = b; in_valid = 1'b1; overflow_clr = clr;
`ifdef TINYML_CAM_FRAME_RESYNC_EN
      in_sof = sof;
`endif
      if (keep) begin
         exp_q.push_back({sof, r[7:0], g[7:0], b[7:0]});
         exp_q.push_back({1'b0, r[15:8], g[15:8], b[15:8]});
      end
      tick();
      in_valid = 1'b0; overflow_clr = 1'b0;
`ifdef TINYML_CAM_FRAME_RESYNC_EN
      in_sof = 1'b0;
`endif
      tick();
   endtask

   task automatic send_pair(input int idx, input bit keep, input bit sof, input bit clr);
      logic [47:0] v;
      v = pair_val(idx);
      send_raw(v[15:0], v[31:16], v[47:32], keep, sof, clr);
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !out_valid) break;
      end
      chk("drain", {31'd0, (exp_q.size() == 0 && !out_valid)}, 32'd1);
      tick();
   endtask

   // Scoreboard: every accepted pixel against the queued pixel and model coords
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("extra_pix", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            if (e[24]) begin
               ex = 0;
               ey = 0;
            end
            chk("pix_rgb", {8'd0, out_red, out_green, out_blue}, {8'd0, e[23:0]});
            chk("pix_xy", {8'd0, out_x, out_y, out_sof, out_eol},
                {8'd0, 11'(ex), 11'(ey), (ex == 0 && ey == 0), (ex == W-1)});
            if (prev_last && out_sof && out_x == 11'd0 && out_y == 11'd0) wrap_seen = 1;
            prev_last = (out_x == 11'(W-1)) && (out_y == 11'(H-1)) && out_eol;
            if (out_eol) eol_cnt++;
            if (ex == W-1) begin
               ex = 0;
               ey = (ey == H-1) ? 0 : ey + 1;
            end else begin
               ex++;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [47:0] v;
      logic [31:0] snap_rgb, snap_xy;
      int          pairs;

      // Reset state
      repeat (3) tick();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_flags", {28'd0, fifo_full, overflow, out_sof, out_eol}, 32'd0);
      chk("rst_xy", {10'd0, out_x, out_y}, 32'd0);
      chk("rst_rgb", {8'd0, out_red, out_green, out_blue}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Latency: single pair, even pixel at N+2, odd at N+3
      out_ready = 1'b1;
      in_red = 16'h2211; in_green = 16'h4433; in_blue = 16'h6655; in_valid = 1'b1;
      exp_q.push_back({1'b0, 24'h113355});
      exp_q.push_back({1'b0, 24'h224466});
      @(negedge clk);
      chk("lat_n0_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_n1_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      chk("lat_n2_valid", {31'd0, out_valid}, 32'd1);
      chk("lat_n2_rgb", {8'd0, out_red, out_green, out_blue}, 32'h113355);
      chk("lat_n2_xy", {8'd0, out_x, out_y, out_sof, out_eol}, {8'd0, 11'd0, 11'd0, 1'b1, 1'b0});
      @(negedge clk);
      chk("lat_n3_valid", {31'd0, out_valid}, 32'd1);
      chk("lat_n3_rgb", {8'd0, out_red, out_green, out_blue}, 32'h224466);
      chk("lat_n3_xy", {8'd0, out_x, out_y, out_sof, out_eol}, {8'd0, 11'd1, 11'd0, 1'b0, 1'b0});
      @(negedge clk);
      chk("lat_n4_valid", {31'd0, out_valid}, 32'd0);
      tick();

      // One full line of pairs at the scaler's peak rate
      eol_cnt = 0;
      for (int i = 0; i < W/2; i++) send_pair(i, 1'b1, 1'b0, 1'b0);
      wait_drain(100);
      chk("line_eol_cnt", eol_cnt, 32'd1);
      chk("line_ovf", {31'd0, overflow}, 32'd0);

      // Overflow: consumer stalled, 20 pairs into a 16-deep FIFO
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) send_pair(300 + i, 1'b1, 1'b0, 1'b0);
      chk("full_at16", {31'd0, fifo_full}, 32'd1);
      chk("ovf_before_drop", {31'd0, overflow}, 32'd0);
      for (int i = 16; i < 19; i++) send_pair(300 + i, 1'b0, 1'b0, 1'b0);
      chk("ovf_set", {31'd0, overflow}, 32'd1);
      send_pair(319, 1'b0, 1'b0, 1'b1);
      chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
      chk("full_held", {31'd0, fifo_full}, 32'd1);
      v = pair_val(300);
      chk("stall_first_pix", {8'd0, out_red, out_green, out_blue}, {8'd0, v[7:0], v[23:16], v[39:32]});
      out_ready = 1'b1;
      wait_drain(200);
      chk("ovf_sticky", {31'd0, overflow}, 32'd1);
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      chk("ovf_clr", {31'd0, overflow}, 32'd0);
      chk("full_cleared", {31'd0, fifo_full}, 32'd0);

      // Three-cycle stall on an even pixel mid-stream
      fork
         begin
            for (int i = 0; i < 6; i++) send_pair(400 + i, 1'b1, 1'b0, 1'b0);
         end
         begin
            repeat (4) tick();
            out_ready = 1'b0;
            @(negedge clk);
            snap_rgb = {8'd0, out_red, out_green, out_blue};
            snap_xy  = {8'd0, out_x, out_y, out_sof, out_eol};
            v = pair_val(401);
            chk("stall_pix", snap_rgb, {8'd0, v[7:0], v[23:16], v[39:32]});
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            repeat (2) begin
               @(negedge clk);
               chk("stall_rgb_hold", {8'd0, out_red, out_green, out_blue}, snap_rgb);
               chk("stall_xy_hold", {8'd0, out_x, out_y, out_sof, out_eol}, snap_xy);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      wait_drain(100);

      // Run through the end of the frame and into the next one
      wrap_seen = 0;
      pairs = (W*H - (ey*W + ex)) / 2 + 2;
      for (int i = 0; i < pairs; i++) send_pair(500 + i, 1'b1, 1'b0, 1'b0);
      wait_drain(100);
      chk("frame_wrap", {31'd0, wrap_seen}, 32'd1);

      // Asynchronous reset with 5 pairs buffered
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send_pair(3000 + i, 1'b1, 1'b0, 1'b0);
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_xy", {10'd0, out_x, out_y}, 32'd0);
      exp_q.delete();
      ex = 0; ey = 0; prev_last = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      send_pair(3100, 1'b1, 1'b0, 1'b0);
      wait_drain(50);

`ifdef TINYML_CAM_FRAME_RESYNC_EN
      // Mid-frame in_sof re-anchors the coordinates
      for (int i = 0; i < 3; i++) send_pair(3200 + i, 1'b1, 1'b0, 1'b0);
      send_pair(3210, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) send_pair(3220 + i, 1'b1, 1'b0, 1'b0);
      wait_drain(50);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
